// File: rtl/dequantizer_if.sv
// +----------------------------------------------------------------------------+
// | Module      : dequantizer_if                                               |
// | Description : Stream bundle for the dequantizer. The slave modport is the  |
// |               dequantizer view (narrow beats in, wide beats out); the      |
// |               master modport is the surrounding datapath view.             |
// | Signals     : shift_i  [SHIFT_BW] per-frame left shift (frame start only)  |
// |               data_i   [O_BW]     signed narrow sample                     |
// |               valid_i/last_i/ready_o  upstream handshake                   |
// |               data_o   [I_BW]     signed widened, saturated sample         |
// |               valid_o/last_o/ready_i  downstream handshake                 |
// |               sat_count_o [16]    only with DEQUANT_SAT_COUNT_EN defined   |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
`default_nettype none

interface dequantizer_if #(
  parameter int I_BW     = 32,
  parameter int O_BW     = 8,
  parameter int SHIFT_BW = $clog2(I_BW)
);
  logic [SHIFT_BW-1:0] shift_i;
  logic [O_BW-1:0]     data_i;
  logic                valid_i;
  logic                last_i;
  logic                ready_o;
  logic [I_BW-1:0]     data_o;
  logic                valid_o;
  logic                last_o;
  logic                ready_i;
`ifdef DEQUANT_SAT_COUNT_EN
  logic [15:0]         sat_count_o;
`endif

  modport slave (
    input  shift_i, data_i, valid_i, last_i, ready_i,
    output ready_o, data_o, valid_o, last_o
`ifdef DEQUANT_SAT_COUNT_EN
    , output sat_count_o
`endif
  );

  modport master (
    output shift_i, data_i, valid_i, last_i, ready_i,
    input  ready_o, data_o, valid_o, last_o
`ifdef DEQUANT_SAT_COUNT_EN
    , input sat_count_o
`endif
  );
endinterface

`default_nettype wire

// File: rtl/dequantizer.sv
// +----------------------------------------------------------------------------+
// | Module      : dequantizer                                                  |
// | Description : Streaming inverse of the output quantizer. Sign-extends a    |
// |               signed O_BW-bit sample, shifts it left by a per-frame amount |
// |               and saturates into a signed I_BW-bit result. Two-stage       |
// |               elastic pipeline, 2-cycle latency, 1 beat/cycle.             |
// | Ports       : clk_i    clock                                               |
// |               rst_n_i  asynchronous active-low reset                       |
// |               bus      dequantizer_if.slave stream bundle                  |
// | Options     : DEQUANT_SAT_COUNT_EN adds bus.sat_count_o, a per-frame       |
// |               count of clamped beats (holds at 0xFFFF).                    |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
`default_nettype none

module dequantizer #(
  parameter int I_BW     = 32,
  parameter int O_BW     = 8,
  parameter int SHIFT_BW = $clog2(I_BW)
) (
  input  wire logic       clk_i,
  input  wire logic       rst_n_i,
  dequantizer_if.slave    bus
);

  localparam int c_WIDE = I_BW + O_BW;

  // Saturation bounds expressed at the full intermediate width.
  localparam logic signed [c_WIDE-1:0] c_MAX_WIDE = {{(O_BW+1){1'b0}}, {(I_BW-1){1'b1}}};
  localparam logic signed [c_WIDE-1:0] c_MIN_WIDE = {{(O_BW+1){1'b1}}, {(I_BW-1){1'b0}}};
  localparam logic [I_BW-1:0]          c_MAX_OUT  = {1'b0, {(I_BW-1){1'b1}}};
  localparam logic [I_BW-1:0]          c_MIN_OUT  = {1'b1, {(I_BW-1){1'b0}}};

  typedef enum logic [0:0] {
    ST_START    = 1'b0,
    ST_IN_FRAME = 1'b1
  } state_t;

  state_t              r_state;
  logic [SHIFT_BW-1:0] r_shift_q;

  logic                r_s1_valid;
  logic [I_BW-1:0]     r_s1_data;
  logic [SHIFT_BW-1:0] r_s1_shift;
  logic                r_s1_last;

  logic                r_s2_valid;
  logic [I_BW-1:0]     r_s2_data;
  logic                r_s2_last;

  logic                w_s2_ready;
  logic                w_s2_load;
  logic                w_s1_ready;
  logic                w_in_fire;
  logic [SHIFT_BW-1:0] w_shift;
  logic signed [c_WIDE-1:0] w_ext;
  logic signed [c_WIDE-1:0] w_wide;
  logic                w_sat_hi;
  logic                w_sat_lo;
  logic [I_BW-1:0]     w_result;

  // Elastic handshake: each stage may load when empty or draining this cycle.
  assign w_s2_ready = !r_s2_valid || bus.ready_i;
  assign w_s2_load  = r_s1_valid && w_s2_ready;
  assign w_s1_ready = !r_s1_valid || w_s2_load;
  // Gated by the reset pin so the block advertises no space while held in reset.
  assign bus.ready_o = rst_n_i && w_s1_ready;
  assign w_in_fire   = bus.valid_i && w_s1_ready;

  // The first beat of a frame uses the live shift; later beats use the latched one.
  assign w_shift = (r_state == ST_START) ? bus.shift_i : r_shift_q;

  // Frame FSM: latch the shift on the first accepted beat of each frame.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_state   <= ST_START;
      r_shift_q <= '0;
    end else if (w_in_fire) begin
      case (r_state)
        ST_START: begin
          r_shift_q <= bus.shift_i;
          if (!bus.last_i) r_state <= ST_IN_FRAME;
        end
        ST_IN_FRAME: begin
          if (bus.last_i) r_state <= ST_START;
        end
        default: r_state <= ST_START;
      endcase
    end
  end

  // Stage 1: sign-extended sample, its shift and frame marker.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_s1_valid <= 1'b0;
      r_s1_data  <= '0;
      r_s1_shift <= '0;
      r_s1_last  <= 1'b0;
    end else if (w_s1_ready) begin
      r_s1_valid <= w_in_fire;
      if (w_in_fire) begin
        r_s1_data  <= {{(I_BW-O_BW){bus.data_i[O_BW-1]}}, bus.data_i};
        r_s1_shift <= w_shift;
        r_s1_last  <= bus.last_i;
      end
    end
  end

  // Shift at I_BW+O_BW bits so no significant bit is lost before the clamp test.
  assign w_ext    = $signed({{O_BW{r_s1_data[I_BW-1]}}, r_s1_data});
  assign w_wide   = w_ext <<< r_s1_shift;
  assign w_sat_hi = (w_wide > c_MAX_WIDE);
  assign w_sat_lo = (w_wide < c_MIN_WIDE);

  always_comb begin
    w_result = w_wide[I_BW-1:0];
    if (w_sat_hi)      w_result = c_MAX_OUT;
    else if (w_sat_lo) w_result = c_MIN_OUT;
  end

  // Stage 2: saturated result, drives the output port directly.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_s2_valid <= 1'b0;
      r_s2_data  <= '0;
      r_s2_last  <= 1'b0;
    end else if (w_s2_ready) begin
      r_s2_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_s2_data <= w_result;
        r_s2_last <= r_s1_last;
      end
    end
  end

  assign bus.data_o  = r_s2_data;
  assign bus.valid_o = r_s2_valid;
  assign bus.last_o  = r_s2_last;

`ifdef DEQUANT_SAT_COUNT_EN
  logic [15:0] r_sat_cnt;
  logic [15:0] w_cnt_base;
  logic        w_cnt_inc;
  logic        w_out_last_fire;

  // Consuming the last beat restarts the count; a clamped beat of the next
  // frame entering S2 on that same edge still gets counted.
  assign w_out_last_fire = r_s2_valid && bus.ready_i && r_s2_last;

  always_comb begin
    w_cnt_base = w_out_last_fire ? 16'd0 : r_sat_cnt;
    w_cnt_inc  = w_s2_load && (w_sat_hi || w_sat_lo) && (w_cnt_base != 16'hFFFF);
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) r_sat_cnt <= '0;
    else          r_sat_cnt <= w_cnt_base + {15'd0, w_cnt_inc};
  end

  assign bus.sat_count_o = r_sat_cnt;
`endif

endmodule

`default_nettype wire
